// File: rtl/stereo_fade_controller_pkg.sv
// rtl/stereo_fade_controller_pkg.sv - shared mode constants, FSM encoding and gain helpers
package stereo_pkg;

  localparam logic [1:0] AURAL_BOTH  = 2'b11;
  localparam logic [1:0] AURAL_LEFT  = 2'b10;
  localparam logic [1:0] AURAL_RIGHT = 2'b01;
  localparam logic [1:0] AURAL_MUTE  = 2'b00;

  typedef enum logic {
    STEADY  = 1'b0,
    RAMPING = 1'b1
  } fade_state_t;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_GAIN_BITS    = 6;

  function automatic int unity_gain(input int gain_bits);
    return 1 << (gain_bits - 1);
  endfunction

endpackage

// File: rtl/stereo_fade_controller_if.sv
// rtl/stereo_fade_controller_if.sv - sample in / scaled stereo out stream bundle
interface stereo_fade_controller_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                           sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] sample_in;
  logic signed [SAMPLE_WIDTH-1:0] left_out;
  logic signed [SAMPLE_WIDTH-1:0] right_out;
  logic                           out_valid;

  modport master (
    output sample_valid, sample_in,
    input  left_out, right_out, out_valid
  );

  modport slave (
    input  sample_valid, sample_in,
    output left_out, right_out, out_valid
  );
endinterface

// File: rtl/stereo_gain_scaler.sv
// rtl/stereo_gain_scaler.sv - combinational signed sample x unsigned gain, rescaled to unity
module stereo_gain_scaler #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_BITS    = 6
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic        [GAIN_BITS-1:0]    gain,
  output logic signed [SAMPLE_WIDTH-1:0] scaled
);
  localparam int PW = SAMPLE_WIDTH + GAIN_BITS + 1;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;

  assign sample_ext = PW'(sample);
  assign gain_ext   = $signed(PW'({1'b0, gain}));
  assign product    = sample_ext * gain_ext;
  // Gain never exceeds unity, so the shifted product always fits the sample width.
  assign scaled     = SAMPLE_WIDTH'(product >>> (GAIN_BITS - 1));
endmodule

// File: rtl/stereo_fade_controller.sv
// rtl/stereo_fade_controller.sv - aural mode to per-channel gain ramps applied to a mono sample stream
module stereo_fade_controller
  import stereo_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int GAIN_BITS    = DEFAULT_GAIN_BITS,
  parameter int RAMP_STEP    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 aural_state,
  stereo_fade_controller_if.slave    smp,
  output logic                       busy,
  output logic [GAIN_BITS-1:0]       left_gain,
  output logic [GAIN_BITS-1:0]       right_gain
);
  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(unity_gain(GAIN_BITS));
  localparam logic [GAIN_BITS-1:0] STEP  = GAIN_BITS'(RAMP_STEP);

  fade_state_t state_q, state_d;

  logic [GAIN_BITS-1:0]           left_tgt, right_tgt;
  logic [GAIN_BITS-1:0]           left_tgt_d, right_tgt_d;
  logic signed [SAMPLE_WIDTH-1:0] left_scaled, right_scaled;
  logic signed [SAMPLE_WIDTH-1:0] left_q, right_q;
  logic                           valid_q;
  logic                           at_target;

  // Move one step toward the target, landing exactly on it when closer than a step.
  function automatic logic [GAIN_BITS-1:0] step_toward(input logic [GAIN_BITS-1:0] g,
                                                      input logic [GAIN_BITS-1:0] t);
    if (g < t) return ((t - g) > STEP) ? g + STEP : t;
    else       return ((g - t) > STEP) ? g - STEP : t;
  endfunction

  always_comb begin
    left_tgt_d  = '0;
    right_tgt_d = '0;
    case (aural_state)
      AURAL_BOTH:  begin left_tgt_d = UNITY; right_tgt_d = UNITY; end
      AURAL_LEFT:  left_tgt_d  = UNITY;
      AURAL_RIGHT: right_tgt_d = UNITY;
      AURAL_MUTE:  ;
      default:     ;
    endcase
  end

  stereo_gain_scaler #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .GAIN_BITS(GAIN_BITS)) u_left_scaler (
    .sample (smp.sample_in),
    .gain   (left_gain),
    .scaled (left_scaled)
  );

  stereo_gain_scaler #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .GAIN_BITS(GAIN_BITS)) u_right_scaler (
    .sample (smp.sample_in),
    .gain   (right_gain),
    .scaled (right_scaled)
  );

  // Scaling reads the pre-update gain; stepping reads the previously registered target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_tgt   <= UNITY;
      right_tgt  <= UNITY;
      left_gain  <= UNITY;
      right_gain <= UNITY;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      left_tgt  <= left_tgt_d;
      right_tgt <= right_tgt_d;
      valid_q   <= smp.sample_valid;
      if (smp.sample_valid) begin
        left_gain  <= step_toward(left_gain, left_tgt);
        right_gain <= step_toward(right_gain, right_tgt);
        left_q     <= left_scaled;
        right_q    <= right_scaled;
      end
    end
  end

  assign smp.left_out  = left_q;
  assign smp.right_out = right_q;
  assign smp.out_valid = valid_q;

  assign at_target = (left_gain == left_tgt) && (right_gain == right_tgt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= STEADY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STEADY:  if (!at_target) state_d = RAMPING;
      RAMPING: if (at_target)  state_d = STEADY;
      default: state_d = STEADY;
    endcase
  end

  always_comb begin
    busy = (state_q == RAMPING);
  end
endmodule

// File: tb/tb_stereo_fade_controller.sv
// tb/tb_stereo_fade_controller.sv - directed and random checks against a per-strobe gain/scale model
module tb_stereo_fade_controller;
  localparam int SW    = 16;
  localparam int GB    = 6;
  localparam int STEP  = 1;
  localparam int UNITY = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    aural_state = 2'b11;
  logic          busy;
  logic [GB-1:0] left_gain, right_gain;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_tl, m_tr, m_gl, m_gr, m_l, m_r, m_ov, m_busy;

  stereo_fade_controller_if #(.SAMPLE_WIDTH(SW)) bus ();

  stereo_fade_controller #(.SAMPLE_WIDTH(SW), .GAIN_BITS(GB), .RAMP_STEP(STEP)) dut (
    .clk         (clk),
    .rst         (rst),
    .aural_state (aural_state),
    .smp         (bus),
    .busy        (busy),
    .left_gain   (left_gain),
    .right_gain  (right_gain)
  );

  always #5 clk = ~clk;

  function automatic int scale(input int s, input int g);
    int p;
    p = s * g;
    if (p >= 0) return p / UNITY;
    else        return -((-p + UNITY - 1) / UNITY);
  endfunction

  function automatic int toward(input int g, input int t);
    if (g < t) return (g + STEP > t) ? t : g + STEP;
    else       return (g - STEP < t) ? t : g - STEP;
  endfunction

  task automatic model_reset();
    m_tl = UNITY; m_tr = UNITY; m_gl = UNITY; m_gr = UNITY;
    m_l = 0; m_r = 0; m_ov = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic v, input int s, input logic [1:0] st);
    m_busy = ((m_gl != m_tl) || (m_gr != m_tr)) ? 1 : 0;
    m_ov   = v ? 1 : 0;
    if (v) begin
      m_l  = scale(s, m_gl);
      m_r  = scale(s, m_gr);
      m_gl = toward(m_gl, m_tl);
      m_gr = toward(m_gr, m_tr);
    end
    m_tl = st[1] ? UNITY : 0;
    m_tr = st[0] ? UNITY : 0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid",  int'(bus.out_valid), m_ov);
    chk("left_out",   int'(bus.left_out), m_l);
    chk("right_out",  int'(bus.right_out), m_r);
    chk("left_gain",  int'(left_gain), m_gl);
    chk("right_gain", int'(right_gain), m_gr);
    chk("busy",       int'(busy), m_busy);
  endtask

  task automatic tick(input logic v, input int s, input logic [1:0] st);
    bus.sample_valid = v;
    bus.sample_in    = SW'(s);
    aural_state      = st;
    @(posedge clk);
    #1;
    model_edge(v, s, st);
    check_all();
  endtask

  initial begin
    int pre_gain;
    int k;
    logic [1:0] st;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 16'sd1000;
    model_reset();

    // 1: reset with a strobe pending, then release
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    tick(1'b1, 1000, 2'b11);
    chk("t1_left_1000", int'(bus.left_out), 1000);
    chk("t1_right_1000", int'(bus.right_out), 1000);
    tick(1'b0, 1000, 2'b11);

    // 2: left only, right ramps down under continuous strobes
    tick(1'b0, 3200, 2'b10);
    for (k = 0; k < 40; k++) begin
      pre_gain = m_gr;
      tick(1'b1, 3200, 2'b10);
      if (pre_gain == 16) chk("t2_right_g16", int'(bus.right_out), 1600);
      if (m_gr == 0 && m_busy == 0) break;
    end
    chk("t2_right_reached_0", int'(right_gain), 0);
    chk("t2_left_held", int'(left_gain), UNITY);
    tick(1'b1, 3200, 2'b10);
    chk("t2_busy_low", int'(busy), 0);

    // 3: back to both, then mute with most-negative input
    for (k = 0; k < 40 && (m_gr != UNITY || m_busy != 0); k++) tick(1'b1, 100, 2'b11);
    tick(1'b1, 100, 2'b11);
    tick(1'b1, -32768, 2'b00);
    chk("t3_first_unity", int'(bus.left_out), -32768);
    for (k = 0; k < 40; k++) tick(1'b1, -32768, 2'b00);
    chk("t3_left_zero", int'(bus.left_out), 0);
    chk("t3_right_zero", int'(bus.right_out), 0);

    // 4: reversal mid-ramp
    for (k = 0; k < 40 && (m_gl != UNITY || m_gr != UNITY); k++) tick(1'b1, 500, 2'b11);
    tick(1'b1, 500, 2'b01);
    for (k = 0; k < 40 && m_gl != 20; k++) tick(1'b1, 500, 2'b01);
    chk("t4_left_at_20", int'(left_gain), 20);
    for (k = 0; k < 20 && m_gl != UNITY; k++) begin
      tick(1'b1, 500, 2'b11);
      chk("t4_busy_high", int'(busy), 1);
    end
    tick(1'b0, 500, 2'b11);
    tick(1'b0, 500, 2'b11);
    chk("t4_busy_done", int'(busy), 0);

    // 5: strobes spaced five cycles apart
    tick(1'b0, 0, 2'b00);
    for (k = 0; k < 12; k++) begin
      tick(1'b1, 700 + k, 2'b00);
      repeat (4) tick(1'b0, -1, 2'b00);
    end

    // 6: asynchronous reset mid-ramp
    for (k = 0; k < 60 && (m_gl != UNITY || m_gr != UNITY); k++) tick(1'b1, 900, 2'b11);
    tick(1'b1, 900, 2'b01);
    for (k = 0; k < 40 && m_gl != 10; k++) tick(1'b1, 900, 2'b01);
    chk("t6_left_at_10", int'(left_gain), 10);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1'b0, 0, 2'b11);
    tick(1'b0, 0, 2'b11);
    chk("t6_busy_after_release", int'(busy), 0);

    // random traffic
    st = 2'b11;
    for (k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) st = 2'($urandom_range(0, 3));
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
